mux2_rr_arbiter: RTL and testbench

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux2_rr_arbiter_pkg.sv | 31 +++
 rtl/mux2_rr_arbiter_stream_out_reg.sv | 72 +++++++
 rtl/mux2_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter_pkg
//
// Definitions shared by the arbiter, its output register and the bench:
//   - arb_state_e : arbiter state encoding (IDLE / OWN_A / OWN_B)
//   - PRIO_*      : values of the round-robin priority pointer
//   - SEL_*       : values driven on the downstream 2:1 select
//   - other_prio  : priority value that hands the next tie to the other side
// ---------------------------------------------------------------------------
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    // Priority pointer: names the requester that wins a tie in IDLE.
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    // Select polarity for the downstream mux.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // When the owner finishes its burst, the next tie goes to the other side.
    function automatic logic other_prio(input arb_state_e owner);
        return (owner == OWN_A) ? PRIO_B : PRIO_A;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_stream_out_reg.sv
// ---------------------------------------------------------------------------
// stream_out_reg
//
// Single-entry valid/ready register holding one beat (data + last flag).
//
// Handshake: upstream may present load_i only while ready_o is high; a beat
// leaves when out_valid_o && out_ready_i on a rising edge. ready_o is high
// when the slot is empty or is being drained this cycle, so a drain and a
// load can happen on the same edge (full throughput).
//
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset
//   load_i       : a beat is accepted upstream this cycle
//   in_data_i    : beat payload
//   in_last_i    : beat is the last of its burst
//   out_ready_i  : downstream can take the held beat
//   ready_o      : slot can take a new beat this cycle
//   out_valid_o  : held beat is valid
//   out_data_o   : held beat payload
//   out_last_o   : held beat last flag
// ---------------------------------------------------------------------------
module stream_out_reg #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load_i,
    input  logic [DATAWIDTH-1:0] in_data_i,
    input  logic                 in_last_i,
    input  logic                 out_ready_i,
    output logic                 ready_o,
    output logic                 out_valid_o,
    output logic [DATAWIDTH-1:0] out_data_o,
    output logic                 out_last_o
);

    // Payload is {last, data} so both fields move and hold together.
    logic [DATAWIDTH:0] payload_q;
    logic [DATAWIDTH:0] payload_d;
    logic               valid_q;
    logic               valid_d;

    always_comb begin
        payload_d = payload_q;
        valid_d   = valid_q;
        if (load_i) begin
            // Covers simultaneous drain + load: valid stays set, new beat in.
            payload_d = {in_last_i, in_data_i};
            valid_d   = 1'b1;
        end else if (out_ready_i) begin
            valid_d   = 1'b0;
        end
    end

    // Payload only changes on load, and load requires ready_o, so the held
    // beat is stable for as long as it is stalled downstream.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            payload_q <= payload_d;
            valid_q   <= valid_d;
        end
    end

    assign ready_o     = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = payload_q[DATAWIDTH-1:0];
    assign out_last_o  = payload_q[DATAWIDTH];

endmodule

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Two-requester burst arbiter feeding one registered output stream. A grant
// is held for a whole burst (until a beat with last is accepted); ties in
// IDLE are broken by a round-robin pointer that flips to the other side at
// the end of every burst. The grant is registered, so every burst begins
// with one IDLE cycle in which nothing is accepted.
//
// Handshake (all streams): a beat moves on a rising edge where valid and
// ready are both high. Valid must not depend on ready. Only the current
// owner sees ready; the other side's ready is held low.
//
// Ports:
//   Clk, Rst            : clock, synchronous active-high reset
//   a_data/a_valid/a_last, a_ready : requester A stream
//   b_data/b_valid/b_last, b_ready : requester B stream
//   out_data/out_valid/out_last, out_ready : shared output stream
//   sel                 : owner select for downstream mux (1 = A, 0 = B)
//   busy                : state is not IDLE
//   dbg_state_o         : current arbiter state (arb_state_e encoding)
//   dbg_prio_o          : current priority pointer (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,

    input  logic [DATAWIDTH-1:0] a_data,
    input  logic                 a_valid,
    input  logic                 a_last,
    output logic                 a_ready,

    input  logic [DATAWIDTH-1:0] b_data,
    input  logic                 b_valid,
    input  logic                 b_last,
    output logic                 b_ready,

    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,

    output logic                 sel,
    output logic                 busy,

    output logic [1:0]           dbg_state_o,
    output logic                 dbg_prio_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       prio_q;
    logic       prio_d;
    logic       sel_q;
    logic       sel_d;

    logic                 slot_ready;
    logic                 accept_a;
    logic                 accept_b;
    logic                 load;
    logic [DATAWIDTH-1:0] steer_data;
    logic                 steer_last;

    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;
    assign load     = accept_a || accept_b;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            prio_q  <= PRIO_A;
            sel_q   <= SEL_A;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;

        case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_d = (prio_q == PRIO_A) ? OWN_A : OWN_B;
                end else if (a_valid) begin
                    state_d = OWN_A;
                end else if (b_valid) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                // The owner may idle mid-burst; only its last beat ends it.
                if (accept_a && a_last) begin
                    state_d = IDLE;
                    prio_d  = other_prio(OWN_A);
                end
            end
            OWN_B: begin
                if (accept_b && b_last) begin
                    state_d = IDLE;
                    prio_d  = other_prio(OWN_B);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // sel follows the owner and keeps its last value through IDLE, so
        // registering it alongside the state keeps it glitch-free downstream.
        if (state_d == OWN_A) begin
            sel_d = SEL_A;
        end else if (state_d == OWN_B) begin
            sel_d = SEL_B;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_q)
            OWN_A:   a_ready = slot_ready;
            OWN_B:   b_ready = slot_ready;
            default: begin
            end
        endcase

        busy        = (state_q != IDLE);
        sel         = sel_q;
        dbg_state_o = state_q;
        dbg_prio_o  = prio_q;

        // Steering only matters while a beat is being accepted, and accepts
        // only happen in OWN_A/OWN_B where sel already names the owner.
        steer_data = (sel_q == SEL_A) ? a_data : b_data;
        steer_last = (sel_q == SEL_A) ? a_last : b_last;
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    stream_out_reg #(
        .DATAWIDTH (DATAWIDTH)
    ) u_out_reg (
        .Clk         (Clk),
        .Rst         (Rst),
        .load_i      (load),
        .in_data_i   (steer_data),
        .in_last_i   (steer_last),
        .out_ready_i (out_ready),
        .ready_o     (slot_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;
    import mux2_rr_arbiter_pkg::*;

    localparam int DW = 64;

    logic          Clk;
    logic          Rst;
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic          a_last;
    logic          a_ready;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_last;
    logic          b_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          sel;
    logic          busy;
    logic [1:0]    dbg_state;
    logic          dbg_prio;

    int n_vec = 0;
    int n_err = 0;

    // Expected output beats as {last, data}.
    logic [DW:0] exp_q[$];

    logic [1:0] st_tbl [8] = '{IDLE, OWN_A, IDLE, OWN_B, IDLE, OWN_A, IDLE, OWN_B};

    logic toggle_en = 1'b0;

    mux2_rr_arbiter #(
        .DATAWIDTH (DW)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .a_data      (a_data),
        .a_valid     (a_valid),
        .a_last      (a_last),
        .a_ready     (a_ready),
        .b_data      (b_data),
        .b_valid     (b_valid),
        .b_last      (b_last),
        .b_ready     (b_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .sel         (sel),
        .busy        (busy),
        .dbg_state_o (dbg_state),
        .dbg_prio_o  (dbg_prio)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every beat leaving the DUT must match the head of the queue.
    always @(negedge Clk) begin
        logic [DW:0] e;
        if (!Rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL mon_unexpected: got %h expected no beat", {out_last, out_data});
            end else begin
                e = exp_q.pop_front();
                check("mon_beat", {out_last, out_data}, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        Rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_out_valid", 65'(out_valid), 65'd0);
        check("rst_out_last",  65'(out_last),  65'd0);
        check("rst_out_data",  65'(out_data),  65'd0);
        check("rst_busy",      65'(busy),      65'd0);
        check("rst_sel",       65'(sel),       65'd1);
        check("rst_state",     65'(dbg_state), 65'(IDLE));
        check("rst_prio",      65'(dbg_prio),  65'd0);
        check("rst_readies",   65'({a_ready, b_ready}), 65'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        exp_q.delete();
    endtask

    // Present one beat on A (is_a=1) or B, hold it until accepted, then drop
    // valid. waits = cycles spent with ready low before the accept.
    task automatic push_beat(input logic is_a, input logic [DW-1:0] d, input logic l,
                             output int waits);
        waits = 0;
        if (is_a) begin
            a_valid = 1'b1; a_data = d; a_last = l;
        end else begin
            b_valid = 1'b1; b_data = d; b_last = l;
        end
        exp_q.push_back({l, d});
        forever begin
            @(negedge Clk);
            if (is_a ? a_ready : b_ready) break;
            waits++;
            if (waits > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL push_timeout: got no accept of %h expected accept within 50 cycles", d);
                break;
            end
        end
        @(posedge Clk);
        #1;
        if (is_a) a_valid = 1'b0;
        else      b_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        Rst       = 1'b1;
        a_valid   = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid   = 1'b0; b_data = '0; b_last = 1'b0;
        out_ready = 1'b0;

        // 3-beat A burst, lone requester.
        do_reset();
        out_ready = 1'b1;
        push_beat(1'b1, 64'h11, 1'b0, w); check("t1_grant_wait", 65'(w), 65'd1);
        push_beat(1'b1, 64'h12, 1'b0, w); check("t1_beat2_wait", 65'(w), 65'd0);
        push_beat(1'b1, 64'h13, 1'b1, w); check("t1_beat3_wait", 65'(w), 65'd0);
        @(negedge Clk);
        check("t1_out_valid", 65'(out_valid), 65'd1);
        check("t1_out_beat",  {out_last, out_data}, {1'b1, 64'h13});
        check("t1_state",     65'(dbg_state), 65'(IDLE));
        check("t1_prio",      65'(dbg_prio),  65'd1);
        check("t1_busy",      65'(busy),      65'd0);
        check("t1_sel_held",  65'(sel),       65'd1);
        @(posedge Clk);
        #1;

        // Both requesting single-beat bursts from reset: A, B, A, B.
        do_reset();
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 64'hA0; a_last = 1'b1;
        b_valid = 1'b1; b_data = 64'hB0; b_last = 1'b1;
        exp_q.push_back({1'b1, 64'hA0});
        exp_q.push_back({1'b1, 64'hB0});
        exp_q.push_back({1'b1, 64'hA0});
        exp_q.push_back({1'b1, 64'hB0});
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            check($sformatf("t2_state_%0d", k), 65'(dbg_state), 65'(st_tbl[k]));
            @(posedge Clk);
            #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;

        // A burst stalled downstream for 4 cycles.
        push_beat(1'b1, 64'h30, 1'b0, w);
        push_beat(1'b1, 64'h31, 1'b0, w);
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 64'h32; a_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("t3_a_ready",   65'(a_ready),   65'd0);
            check("t3_out_valid", 65'(out_valid), 65'd1);
            check("t3_out_data",  65'(out_data),  65'h31);
            check("t3_state",     65'(dbg_state), 65'(OWN_A));
            @(posedge Clk);
            #1;
        end
        out_ready = 1'b1;
        push_beat(1'b1, 64'h32, 1'b0, w); check("t3_release_wait", 65'(w), 65'd0);
        push_beat(1'b1, 64'h33, 1'b1, w);

        // B owns the bus and pauses for 5 cycles while A waits.
        a_valid = 1'b1; a_data = 64'h50; a_last = 1'b1;
        push_beat(1'b0, 64'h40, 1'b0, w); check("t4_b_wins_wait", 65'(w), 65'd1);
        push_beat(1'b0, 64'h41, 1'b0, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check("t4_a_ready", 65'(a_ready),   65'd0);
            check("t4_state",   65'(dbg_state), 65'(OWN_B));
            check("t4_sel",     65'(sel),       65'd0);
            @(posedge Clk);
            #1;
        end
        push_beat(1'b0, 64'h42, 1'b1, w); check("t4_resume_wait", 65'(w), 65'd0);
        push_beat(1'b1, 64'h50, 1'b1, w); check("t4_a_after_b_wait", 65'(w), 65'd1);

        // Reset while a beat is held in the output register.
        push_beat(1'b1, 64'h60, 1'b0, w);
        out_ready = 1'b0;
        @(negedge Clk);
        check("t5_pre_state", 65'(dbg_state), 65'(OWN_A));
        check("t5_pre_valid", 65'(out_valid), 65'd1);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        a_valid = 1'b1; a_data = 64'h61; a_last = 1'b0;
        exp_q.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        a_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        check("t5_out_valid", 65'(out_valid), 65'd0);
        check("t5_out_data",  65'(out_data),  65'd0);
        check("t5_state",     65'(dbg_state), 65'(IDLE));
        check("t5_prio",      65'(dbg_prio),  65'd0);
        check("t5_sel",       65'(sel),       65'd1);
        check("t5_busy",      65'(busy),      65'd0);
        @(posedge Clk);
        #1;

        // 8-beat B burst with out_ready toggling every cycle.
        toggle_en = 1'b1;
        fork
            begin
                while (toggle_en) begin
                    @(posedge Clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            push_beat(1'b0, 64'h70 + 64'(i), (i == 7), w);
        end
        toggle_en = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        out_ready = 1'b1;

        // Drain whatever is left and confirm nothing is outstanding.
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (exp_q.size() == 0) break;
        end
        check("final_queue_empty", 65'(exp_q.size()), 65'd0);
        @(negedge Clk);
        check("final_out_valid", 65'(out_valid), 65'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
